// File: rtl/bc_dest_ctrl.sv
// rtl/bc_dest_ctrl.sv - destination sequencer in front of the barcode reader
// Arms motion toward a station ID, consumes reader IDs, stops on match, faults on watchdog/pass limit.
module bc_dest_ctrl #(
  parameter int unsigned       TMO_W    = 24,
  parameter logic [TMO_W-1:0]  TMO_CYC  = 24'd10_000_000,
  parameter logic [3:0]        MAX_PASS = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vld_i,
  input  logic [7:0] cmd_i,
  input  logic       abort_i,
  input  logic       ID_vld_i,
  input  logic [7:0] ID_i,
  output logic       cmd_rdy_o,
  output logic       clr_cmd_o,
  output logic       cmd_err_o,
  output logic       clr_ID_vld_o,
  output logic       go_o,
  output logic       arrived_o,
  output logic       fault_o,
  output logic [3:0] pass_cnt_o,
  output logic [7:0] last_id_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_ARRIVED,
    S_FAULT
  } state_t;

  state_t           state_q;
  logic [5:0]       dest_q;
  logic [TMO_W-1:0] timer_q;
  logic             cmd_rdy_q;
  logic             clr_cmd_q;
  logic             cmd_err_q;
  logic             clr_ID_vld_q;
  logic             go_q;
  logic             arrived_q;
  logic             fault_q;
  logic [3:0]       pass_cnt_q;
  logic [7:0]       last_id_q;

  logic [3:0]       pass_cnt_d;
  logic             id_take;
  logic             id_match;

  // The reader only drops ID_vld on the edge after our pulse, so skip that one cycle.
  assign id_take    = ID_vld_i && !clr_ID_vld_q;
  assign id_match   = (last_id_q == {2'b00, dest_q});
  assign pass_cnt_d = pass_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dest_q       <= '0;
      timer_q      <= '0;
      cmd_rdy_q    <= 1'b0;
      clr_cmd_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      clr_ID_vld_q <= 1'b0;
      go_q         <= 1'b0;
      arrived_q    <= 1'b0;
      fault_q      <= 1'b0;
      pass_cnt_q   <= '0;
      last_id_q    <= '0;
    end else begin
      clr_cmd_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      clr_ID_vld_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ARRIVED, S_FAULT: begin
          cmd_rdy_q <= 1'b1;
          if (id_take) begin
            clr_ID_vld_q <= 1'b1;
          end
          if (cmd_vld_i) begin
            clr_cmd_q <= 1'b1;
            if (cmd_i[7:6] == 2'b00) begin
              dest_q     <= cmd_i[5:0];
              pass_cnt_q <= '0;
              arrived_q  <= 1'b0;
              fault_q    <= 1'b0;
              timer_q    <= TMO_CYC;
              go_q       <= 1'b1;
              cmd_rdy_q  <= 1'b0;
              state_q    <= S_ARMED;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          timer_q <= timer_q - TMO_W'(1);
          if (abort_i) begin
            go_q      <= 1'b0;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (id_take) begin
            last_id_q    <= ID_i;
            clr_ID_vld_q <= 1'b1;
            state_q      <= S_CHECK;
          end else if (timer_q == TMO_W'(1)) begin
            go_q      <= 1'b0;
            fault_q   <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_FAULT;
          end
        end
        S_CHECK: begin
          if (id_match) begin
            go_q      <= 1'b0;
            arrived_q <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state_q   <= S_ARRIVED;
          end else if (pass_cnt_d == MAX_PASS) begin
            pass_cnt_q <= MAX_PASS;
            go_q       <= 1'b0;
            fault_q    <= 1'b1;
            cmd_rdy_q  <= 1'b1;
            state_q    <= S_FAULT;
          end else begin
            pass_cnt_q <= pass_cnt_d;
            timer_q    <= TMO_CYC;
            state_q    <= S_ARMED;
          end
        end
        default: begin
          go_q      <= 1'b0;
          cmd_rdy_q <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_rdy_o    = cmd_rdy_q;
  assign clr_cmd_o    = clr_cmd_q;
  assign cmd_err_o    = cmd_err_q;
  assign clr_ID_vld_o = clr_ID_vld_q;
  assign go_o         = go_q;
  assign arrived_o    = arrived_q;
  assign fault_o      = fault_q;
  assign pass_cnt_o   = pass_cnt_q;
  assign last_id_o    = last_id_q;

endmodule
